// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake, flush and bubble output.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4,
  parameter int CTRL_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] in_data,
  input  logic [CTRL_W-1:0]           in_ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_data,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 flush_cnt
);

  localparam int DATA_W  = NUM_WORDS * WORD_W;
  localparam int ENTRY_W = DATA_W + CTRL_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state, state_next;
  logic [ENTRY_W-1:0] main_q, main_next;
  logic [ENTRY_W-1:0] skid_q, skid_next;
  logic [ENTRY_W-1:0] in_entry;
  logic               in_fire, out_fire;

  assign in_entry  = {in_ctrl, in_data};
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // The head register can hold a stale entry after draining, so the outputs are gated to a bubble.
  assign out_data = out_valid ? main_q[DATA_W-1:0] : '0;
  assign out_ctrl = out_valid ? main_q[ENTRY_W-1:DATA_W] : '0;

  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_next  = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_entry;
          end else if (in_fire) begin
            state_next = FULL;
            skid_next  = in_entry;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_next = ONE;
            main_next  = skid_q;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic [1:0]  flush_inc;
  logic [16:0] flush_sum;

  // Squashed entries: held ones not leaving this cycle, plus an upstream entry presented during flush.
  always_comb begin
    unique case (state)
      ONE:     flush_inc = 2'd1;
      FULL:    flush_inc = 2'd2;
      default: flush_inc = 2'd0;
    endcase
    if (out_fire) flush_inc = flush_inc - 2'd1;
    if (in_valid) flush_inc = flush_inc + 2'd1;
    flush_sum = {1'b0, flush_q} + {15'd0, flush_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush) flush_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed literal checks.
// Counter expectations follow PIPE_STAGE_PERF_EN when it is defined for the build.
module tb_pipe_stage_skid;

  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = 2;
  localparam int CTRL_W    = 16;
  localparam int DATA_W    = WORD_W * NUM_WORDS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model: an ordered list of held entries {ctrl, data}, at most two deep.
  logic [CTRL_W+DATA_W-1:0] model_q[$];
  int  model_stall = 0;
  int  model_flush = 0;
  bit  model_known = 1'b0;

  pipe_stage_skid #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    logic [CTRL_W+DATA_W-1:0] head;
    int exp_stall, exp_flush;
    if (!model_known) return;
    head = (model_q.size() > 0) ? model_q[0] : '0;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = model_stall;
    exp_flush = model_flush;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    check("in_ready",  32'(in_ready),  32'(model_q.size() < 2));
    check("out_data",  32'(out_data),  32'(head[DATA_W-1:0]));
    check("out_ctrl",  32'(out_ctrl),  32'(head[CTRL_W+DATA_W-1:DATA_W]));
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    int  held;
    bit  acc, take;
    held = model_q.size();
    acc  = in_valid && (held < 2);
    take = out_ready && (held > 0);
    if (reset) begin
      model_q.delete();
      model_stall = 0;
      model_flush = 0;
      model_known = 1'b1;
      return;
    end
    if (take && !out_ready) model_stall = model_stall;
    if (held > 0 && !out_ready) model_stall = (model_stall < 65535) ? model_stall + 1 : 65535;
    if (flush) begin
      model_flush += held - int'(take) + int'(in_valid);
      if (model_flush > 65535) model_flush = 65535;
      model_q.delete();
    end else begin
      if (take) void'(model_q.pop_front());
      if (acc) model_q.push_back({in_ctrl, in_data});
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit fl, input bit iv, input bit ordy,
                               input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
    in_ctrl   = c;
    @(negedge clk);
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] held_data;
    int seq;

    // Reset, then a continuous stream with downstream always ready.
    applyStimulus(1, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 0, 1, '0, '0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 1, 1, DATA_W'(k * 17), CTRL_W'(k));
      check("stream_ctrl",     32'(out_ctrl), 32'(k));
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, '0, '0);
    check("stream_drained", 32'(out_valid), 32'd0);

    // Fill the skid slot, then drain in order.
    applyStimulus(0, 0, 1, 0, 16'h00AA, 16'h000A);
    applyStimulus(0, 0, 1, 0, 16'h00BB, 16'h000B);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head",     32'(out_ctrl), 32'h000A);
    applyStimulus(0, 0, 0, 1, '0, '0);
    check("drain_second",   32'(out_ctrl), 32'h000B);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, '0, '0);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Flush while full with a new entry presented upstream.
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, 0, 16'h1111, 16'h00A1);
    applyStimulus(0, 0, 1, 0, 16'h2222, 16'h00B2);
    applyStimulus(0, 1, 1, 0, 16'h3333, 16'h00C3);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_ctrl",  32'(out_ctrl),  32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("flush_cnt_lit", 32'(flush_cnt), 32'd3);
`else
    check("flush_cnt_lit", 32'(flush_cnt), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1, '0, '0);
      check("flush_no_c", 32'(out_valid), 32'd0);
    end

    // Five stalled cycles with a held head entry.
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, 0, 16'h5A5A, 16'h0055);
    held_data = out_data;
    check("stall_head_data", 32'(held_data), 32'h5A5A);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      check("stall_data_const", 32'(out_data), 32'(held_data));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt_lit", 32'(stall_cnt), 32'd5);
`else
    check("stall_cnt_lit", 32'(stall_cnt), 32'd0);
`endif

    // Reset while full discards everything; the next push behaves normally.
    applyStimulus(0, 0, 1, 0, 16'h6666, 16'h0066);
    check("pre_reset_full", 32'(in_ready), 32'd0);
    applyStimulus(1, 0, 1, 0, 16'h7777, 16'h0077);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
    applyStimulus(0, 0, 1, 1, 16'h0D0D, 16'h00DD);
    check("post_rst_push", 32'(out_ctrl), 32'h00DD);

    // Random handshake traffic with occasional flushes; sequence numbers in ctrl expose reordering.
    seq = 1;
    for (int k = 0; k < 600; k++) begin
      bit iv, ordy, fl;
      iv   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 1) == 1;
      fl   = $urandom_range(0, 39) == 0;
      applyStimulus(0, fl, iv, ordy, DATA_W'($urandom), CTRL_W'(seq));
      if (iv && !fl && in_ready) seq++;
      else if (iv && !fl) seq++;
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, '0, '0);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
